// File: rtl/fifo_pkg.sv
// Shared definitions for the flop-based synchronous FIFOs and their read-side stream adapter.
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH   = 32;
  localparam int FIFO_DEFAULT_DEPTH   = 16;
  localparam int FIFO_RD_STREAM_DEPTH = 2;

  // Only the combinational (0) and registered (1) read-data FIFO flavours exist.
  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat == 0) || (rd_lat == 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry ring buffer between the FIFO read port and the stream output.
// The head word, its valid flag and the occupancy are all presented from flops.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       cnt
);

  logic [FIFO_RD_STREAM_DEPTH-1:0][WIDTH-1:0] entry_r;
  logic [FIFO_RD_STREAM_DEPTH-1:0][WIDTH-1:0] entry_nxt_s;
  logic                                       head_r;
  logic                                       head_nxt_s;
  logic                                       tail_r;
  logic                                       tail_nxt_s;
  logic [1:0]                                 cnt_r;
  logic [1:0]                                 cnt_nxt_s;
  logic                                       valid_r;
  logic [WIDTH-1:0]                           head_data_r;

  // Next ring state from push/pop; 1-bit pointers wrap on their own
  always_comb begin
    entry_nxt_s = entry_r;
    if (push) begin
      entry_nxt_s[tail_r] = push_data;
    end else begin
      entry_nxt_s = entry_r;
    end
    head_nxt_s = head_r ^ pop;
    tail_nxt_s = tail_r ^ push;
    cnt_nxt_s  = cnt_r + {1'b0, push} - {1'b0, pop};
  end

  // Ring registers; head word is looked up from next state so out_data is a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_r     <= '0;
      head_r      <= 1'b0;
      tail_r      <= 1'b0;
      cnt_r       <= 2'd0;
      valid_r     <= 1'b0;
      head_data_r <= '0;
    end else begin
      entry_r     <= entry_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      cnt_r       <= cnt_nxt_s;
      valid_r     <= (cnt_nxt_s != 2'd0);
      head_data_r <= entry_nxt_s[head_nxt_s];
    end
  end

  assign head_valid = valid_r;
  assign head_data  = head_data_r;
  assign cnt        = cnt_r;

endmodule

// File: rtl/fifo_rd_stream_chk.sv
// Invariant checks for the FIFO read-stream adapter.
module fifo_rd_stream_chk (
  input logic       clk,
  input logic       rst,
  input logic       fifo_empty,
  input logic       fifo_rd_en,
  input logic       out_valid,
  input logic [1:0] buf_cnt
);

  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

  a_cnt_max: assert property (@(posedge clk) disable iff (rst)
    buf_cnt <= 2'd2);

  a_valid_matches_cnt: assert property (@(posedge clk) disable iff (rst)
    out_valid == (buf_cnt != 2'd0));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns a FIFO empty/rd_en/rd_data pull port into a
// first-word-fall-through valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_DEFAULT_WIDTH,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       buf_cnt
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("fifo_rd_stream: RD_LAT must be 0 or 1, got %0d", RD_LAT);
  end

  logic       pop_s;
  logic       push_s;
  logic       inflight_s;
  logic [2:0] occ_s;
  logic       rd_en_s;

  // Issue a read only when the buffer can absorb it, counting words already in flight
  always_comb begin
    pop_s = out_valid & out_ready;
    occ_s = {1'b0, buf_cnt} + {2'b00, inflight_s} - {2'b00, pop_s};
    if (rst) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = !fifo_empty && (occ_s < 3'd2);
    end
  end

  assign fifo_rd_en = rd_en_s;

  if (RD_LAT == 1) begin : g_lat1
    logic inflight_r;

    // Registered-read FIFO: the word requested this cycle lands on the next edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inflight_r <= 1'b0;
      end else begin
        inflight_r <= rd_en_s;
      end
    end

    assign inflight_s = inflight_r;
    assign push_s     = inflight_r;
  end else begin : g_lat0
    assign inflight_s = 1'b0;
    assign push_s     = rd_en_s;
  end

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .push_data  (fifo_rd_data),
    .head_valid (out_valid),
    .head_data  (out_data),
    .cnt        (buf_cnt)
  );

  fifo_rd_stream_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (rd_en_s),
    .out_valid  (out_valid),
    .buf_cnt    (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency, each fed by a queue-based FIFO model.
module tb_fifo_rd_stream;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         empty0, empty1;
  logic [W-1:0] rd_data0, rd_data1;
  logic         rd_en0, rd_en1;
  logic         valid0, valid1;
  logic [W-1:0] data0, data1;
  logic         ready0, ready1;
  logic [1:0]   cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(W), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_rd_data(rd_data0), .fifo_rd_en(rd_en0),
    .out_valid(valid0), .out_data(data0), .out_ready(ready0), .buf_cnt(cnt0));

  fifo_rd_stream #(.WIDTH(W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_rd_data(rd_data1), .fifo_rd_en(rd_en1),
    .out_valid(valid1), .out_data(data1), .out_ready(ready1), .buf_cnt(cnt1));

  // FIFO contents (fq) and the words the stream must deliver, in write order (exp)
  logic [W-1:0] fq0[$];
  logic [W-1:0] fq1[$];
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int checks = 0;
  int errors = 0;

  logic         s_en0, s_e0, s_v0, s_r0, s_en1, s_e1, s_v1, s_r1;
  logic [1:0]   s_c0, s_c1;
  logic [W-1:0] s_d0, s_d1;

  task automatic refresh();
    empty0   = (fq0.size() == 0);
    rd_data0 = empty0 ? {W{1'b0}} : fq0[0];
    empty1   = (fq1.size() == 0);
  endtask

  // Sample everything mid-cycle, then advance the FIFO models past the next edge.
  task automatic step();
    @(negedge clk);
    s_en0 = rd_en0; s_e0 = empty0; s_v0 = valid0; s_r0 = ready0; s_c0 = cnt0; s_d0 = data0;
    s_en1 = rd_en1; s_e1 = empty1; s_v1 = valid1; s_r1 = ready1; s_c1 = cnt1; s_d1 = data1;
    @(posedge clk);
    #1;
    if (s_en0 && fq0.size() != 0) void'(fq0.pop_front());
    if (s_en1 && fq1.size() != 0) rd_data1 = fq1.pop_front();
    refresh();
  endtask

  task automatic fifo_wr(input int ch, input logic [W-1:0] v);
    if (ch == 0) begin
      fq0.push_back(v); exp0.push_back(v);
    end else begin
      fq1.push_back(v); exp1.push_back(v);
    end
    refresh();
  endtask

  task automatic flush_models();
    fq0.delete(); fq1.delete(); exp0.delete(); exp1.delete();
    rd_data1 = {W{1'b0}};
    refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
    flush_models();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks += 6;
      if (s_en0 !== 1'b0 || s_en1 !== 1'b0) begin errors++; $display("FAIL reset_rd_en k=%0d got %b%b want 00", k, s_en0, s_en1); end
      if (s_v0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 k=%0d got %b want 0", k, s_v0); end
      if (s_v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 k=%0d got %b want 0", k, s_v1); end
      if (s_c0 !== 2'd0) begin errors++; $display("FAIL reset_cnt0 k=%0d got %0d want 0", k, s_c0); end
      if (s_c1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 k=%0d got %0d want 0", k, s_c1); end
      if (s_d0 !== {W{1'b0}} || s_d1 !== {W{1'b0}}) begin errors++; $display("FAIL reset_data k=%0d got %h %h want 0", k, s_d0, s_d1); end
    end
  endtask

  // Preloaded 0..7: the registered-read instance shows data two cycles after its first
  // read, the combinational-read instance one cycle after; both then stream gap-free.
  task automatic test_stream();
    logic want_v0, want_v1;
    rst = 1'b1;
    flush_models();
    for (int i = 0; i < 8; i++) begin
      fifo_wr(0, W'(i)); fifo_wr(1, W'(i));
    end
    ready0 = 1'b1; ready1 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      want_v0 = (k >= 1 && k <= 8);
      want_v1 = (k >= 2 && k <= 9);
      if (k == 0) begin
        checks++;
        if (s_en1 !== 1'b1) begin errors++; $display("FAIL stream_first_rd_en got %b want 1", s_en1); end
      end
      checks += 2;
      if (s_v0 !== want_v0) begin errors++; $display("FAIL stream_valid0 k=%0d got %b want %b", k, s_v0, want_v0); end
      if (s_v1 !== want_v1) begin errors++; $display("FAIL stream_valid1 k=%0d got %b want %b", k, s_v1, want_v1); end
      if (s_v0 && s_r0 && exp0.size() != 0) begin
        checks++;
        if (s_d0 !== exp0[0]) begin errors++; $display("FAIL stream_data0 k=%0d got %h want %h", k, s_d0, exp0[0]); end
        void'(exp0.pop_front());
      end
      if (s_v1 && s_r1 && exp1.size() != 0) begin
        checks++;
        if (s_d1 !== exp1[0]) begin errors++; $display("FAIL stream_data1 k=%0d got %h want %h", k, s_d1, exp1[0]); end
        void'(exp1.pop_front());
      end
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin errors++; $display("FAIL stream_left got %0d/%0d want 0/0", exp0.size(), exp1.size()); end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) fifo_wr(1, W'(32'hA0 + i));
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_en1) pulses++;
      if (s_v1) begin
        checks++;
        if (s_d1 !== 32'h0000_00A0) begin errors++; $display("FAIL bp_hold_data k=%0d got %h want a0", k, s_d1); end
      end
    end
    checks += 3;
    if (pulses != 2) begin errors++; $display("FAIL bp_rd_pulses got %0d want 2", pulses); end
    if (s_c1 !== 2'd2) begin errors++; $display("FAIL bp_cnt got %0d want 2", s_c1); end
    if (s_d1 !== 32'h0000_00A0) begin errors++; $display("FAIL bp_data got %h want a0", s_d1); end
    ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s_v1 !== 1'b1) begin errors++; $display("FAIL bp_bubble k=%0d got valid %b want 1", k, s_v1); end
      else if (exp1.size() != 0) begin
        checks++;
        if (s_d1 !== exp1[0]) begin errors++; $display("FAIL bp_order k=%0d got %h want %h", k, s_d1, exp1[0]); end
        void'(exp1.pop_front());
      end
    end
    repeat (2) step();
    checks++;
    if (s_v1 !== 1'b0 || exp1.size() != 0) begin errors++; $display("FAIL bp_drain got valid %b left %0d want 0 0", s_v1, exp1.size()); end
  endtask

  task automatic test_push_pop_full();
    int full_pp = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [W-1:0] pd = '0;
    ready0 = 1'b0;
    for (int i = 0; i < 16; i++) fifo_wr(0, W'(32'h10 + i));
    for (int k = 0; k < 80; k++) begin
      step();
      checks += 2;
      if (s_c0 > 2'd2) begin errors++; $display("FAIL pp_cnt k=%0d got %0d want <=2", k, s_c0); end
      if (s_en0 && s_e0) begin errors++; $display("FAIL pp_rd_empty k=%0d got rd_en 1 want 0", k); end
      if (pv && !pr) begin
        checks++;
        if (s_v0 !== 1'b1 || s_d0 !== pd) begin errors++; $display("FAIL pp_stable k=%0d got %b/%h want 1/%h", k, s_v0, s_d0, pd); end
      end
      if (s_c0 == 2'd2 && s_v0 && s_r0 && s_en0) full_pp++;
      if (s_v0 && s_r0) begin
        checks++;
        if (exp0.size() == 0) begin errors++; $display("FAIL pp_extra k=%0d got %h want none", k, s_d0); end
        else begin
          if (s_d0 !== exp0[0]) begin errors++; $display("FAIL pp_order k=%0d got %h want %h", k, s_d0, exp0[0]); end
          void'(exp0.pop_front());
        end
      end
      pv = s_v0; pr = s_r0; pd = s_d0;
      ready0 = ~ready0;
    end
    checks += 2;
    if (exp0.size() != 0) begin errors++; $display("FAIL pp_dropped got %0d left want 0", exp0.size()); end
    if (full_pp == 0) begin errors++; $display("FAIL pp_full_pushpop got %0d want >0", full_pp); end
  endtask

  task automatic test_reset_midop();
    int pops0 = 0, pops1 = 0;
    ready0 = 1'b0; ready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifo_wr(0, W'(32'hE0 + i)); fifo_wr(1, W'(32'hE0 + i));
    end
    repeat (4) step();
    checks += 2;
    if (s_c0 !== 2'd2) begin errors++; $display("FAIL mid_pre_cnt0 got %0d want 2", s_c0); end
    if (s_c1 !== 2'd2) begin errors++; $display("FAIL mid_pre_cnt1 got %0d want 2", s_c1); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL mid_valid got %b%b want 00", valid0, valid1); end
    if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++; $display("FAIL mid_cnt got %0d %0d want 0 0", cnt0, cnt1); end
    if (data0 !== {W{1'b0}} || data1 !== {W{1'b0}}) begin errors++; $display("FAIL mid_data got %h %h want 0", data0, data1); end
    if (rd_en0 !== 1'b0 || rd_en1 !== 1'b0) begin errors++; $display("FAIL mid_rd_en got %b%b want 00", rd_en0, rd_en1); end
    flush_models();
    @(posedge clk);
    #1;
    fifo_wr(0, 32'h0000_0055); fifo_wr(1, 32'h0000_0055);
    ready0 = 1'b1; ready1 = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_v0 && s_r0) begin
        pops0++; checks++;
        if (s_d0 !== 32'h0000_0055) begin errors++; $display("FAIL mid_first0 got %h want 55", s_d0); end
      end
      if (s_v1 && s_r1) begin
        pops1++; checks++;
        if (s_d1 !== 32'h0000_0055) begin errors++; $display("FAIL mid_first1 got %h want 55", s_d1); end
      end
    end
    checks += 2;
    if (pops0 != 1) begin errors++; $display("FAIL mid_pops0 got %0d want 1", pops0); end
    if (pops1 != 1) begin errors++; $display("FAIL mid_pops1 got %0d want 1", pops1); end
    flush_models();
  endtask

  task automatic test_random();
    int w0 = 0, w1 = 0, cyc = 0;
    logic pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
    logic [W-1:0] pd0 = '0, pd1 = '0;
    ready0 = 1'b0; ready1 = 1'b0;
    while ((w0 < 1000 || w1 < 1000 || exp0.size() != 0 || exp1.size() != 0) && cyc < 20000) begin
      step();
      cyc++;
      checks += 4;
      if (s_c0 > 2'd2 || s_c1 > 2'd2) begin errors++; $display("FAIL rnd_cnt c=%0d got %0d %0d want <=2", cyc, s_c0, s_c1); end
      if ((s_en0 && s_e0) || (s_en1 && s_e1)) begin errors++; $display("FAIL rnd_rd_empty c=%0d got rd_en while empty", cyc); end
      if (pv0 && !pr0 && (s_v0 !== 1'b1 || s_d0 !== pd0)) begin errors++; $display("FAIL rnd_stable0 c=%0d got %b/%h want 1/%h", cyc, s_v0, s_d0, pd0); end
      if (pv1 && !pr1 && (s_v1 !== 1'b1 || s_d1 !== pd1)) begin errors++; $display("FAIL rnd_stable1 c=%0d got %b/%h want 1/%h", cyc, s_v1, s_d1, pd1); end
      if (s_v0 && s_r0) begin
        checks++;
        if (exp0.size() == 0) begin errors++; $display("FAIL rnd_dup0 c=%0d got %h want none", cyc, s_d0); end
        else begin
          if (s_d0 !== exp0[0]) begin errors++; $display("FAIL rnd_data0 c=%0d got %h want %h", cyc, s_d0, exp0[0]); end
          void'(exp0.pop_front());
        end
      end
      if (s_v1 && s_r1) begin
        checks++;
        if (exp1.size() == 0) begin errors++; $display("FAIL rnd_dup1 c=%0d got %h want none", cyc, s_d1); end
        else begin
          if (s_d1 !== exp1[0]) begin errors++; $display("FAIL rnd_data1 c=%0d got %h want %h", cyc, s_d1, exp1[0]); end
          void'(exp1.pop_front());
        end
      end
      pv0 = s_v0; pr0 = s_r0; pd0 = s_d0;
      pv1 = s_v1; pr1 = s_r1; pd1 = s_d1;
      if (w0 < 1000 && $urandom_range(0, 1) == 1) begin fifo_wr(0, $urandom); w0++; end
      if (w1 < 1000 && $urandom_range(0, 1) == 1) begin fifo_wr(1, $urandom); w1++; end
      ready0 = ($urandom_range(0, 3) != 0);
      ready1 = ($urandom_range(0, 1) == 1);
    end
    checks += 2;
    if (exp0.size() != 0 || fq0.size() != 0) begin errors++; $display("FAIL rnd_drop0 got %0d undelivered want 0", exp0.size()); end
    if (exp1.size() != 0 || fq1.size() != 0) begin errors++; $display("FAIL rnd_drop1 got %0d undelivered want 0", exp1.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_push_pop_full();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
